// File: rtl/ceespu_int_ctrl.sv
// Interrupt request initiator for the ceespu decoder: synchronise, edge-detect, mask, prioritise, handshake.
// Define CEESPU_INT_LEVEL_EN to make the sources level-sensitive (edge detection bypassed).
module ceespu_int_ctrl #(
    parameter int         NUM_SRC     = 4,
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] MASK_RESET  = 4'b1111
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic [NUM_SRC-1:0] I_irq,
    input  logic               I_mask_we,
    input  logic [NUM_SRC-1:0] I_mask_data,
    input  logic [NUM_SRC-1:0] I_clr_pending,
    input  logic               I_int_ack,
    output logic               O_int,
    output logic [1:0]         O_int_vector,
    output logic [NUM_SRC-1:0] O_pending,
    output logic [NUM_SRC-1:0] O_mask
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

    state_t                               state_q, state_d;
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0]  sync_q;
    logic [NUM_SRC-1:0]                   sync_out;
    logic [NUM_SRC-1:0]                   set;
    logic [NUM_SRC-1:0]                   pending_q, pending_d;
    logic [NUM_SRC-1:0]                   mask_q, mask_d;
    logic [NUM_SRC-1:0]                   cand;
    logic [NUM_SRC-1:0]                   ack_clr;
    logic [1:0]                           vec_q, vec_d;
    logic [1:0]                           winner;
    logic                                 int_q, int_d;
    logic                                 retire;

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef CEESPU_INT_LEVEL_EN
    assign set = sync_out;
`else
    logic [NUM_SRC-1:0] prev_q;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_out;
        end
    end

    assign set = sync_out & ~prev_q;
`endif

    // Retire clears only the bit that was latched when the request was issued.
    assign retire = (state_q == REQ) && I_int_ack;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ack_clr
            assign ack_clr[gi] = retire && (vec_q == 2'(gi));
        end
    endgenerate

    // Clear first, then OR in new sets so a coinciding edge is never lost.
    assign pending_d = (pending_q & ~(I_clr_pending | ack_clr)) | set;
    assign mask_d    = I_mask_we ? I_mask_data : mask_q;
    assign cand      = pending_q & mask_q;

    always_comb begin
        winner = 2'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        case (state_q)
            IDLE: begin
                if (cand != '0) begin
                    state_d = REQ;
                    vec_d   = winner;
                end
            end
            REQ: begin
                if (I_int_ack) begin
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!I_int_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        int_d = (state_d == REQ);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            sync_q    <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RESET[NUM_SRC-1:0];
            vec_q     <= 2'd0;
            int_q     <= 1'b0;
            state_q   <= IDLE;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], I_irq};
            pending_q <= pending_d;
            mask_q    <= mask_d;
            vec_q     <= vec_d;
            int_q     <= int_d;
            state_q   <= state_d;
        end
    end

    assign O_int        = int_q;
    assign O_int_vector = vec_q;
    assign O_pending    = pending_q;
    assign O_mask       = mask_q;

endmodule

// File: tb/tb_ceespu_int_ctrl.sv
// Directed bench for ceespu_int_ctrl in its default edge-triggered build.
module tb_ceespu_int_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] irq = 4'b0000;
    logic       mask_we = 1'b0;
    logic [3:0] mask_data = 4'b0000;
    logic [3:0] clr = 4'b0000;
    logic       ack = 1'b0;
    logic       o_int;
    logic [1:0] o_vec;
    logic [3:0] o_pend;
    logic [3:0] o_mask;

    int tests = 0;
    int fails = 0;

    ceespu_int_ctrl #(
        .NUM_SRC    (4),
        .SYNC_STAGES(2),
        .MASK_RESET (4'b1111)
    ) dut (
        .I_clk        (clk),
        .I_rst_n      (rst_n),
        .I_irq        (irq),
        .I_mask_we    (mask_we),
        .I_mask_data  (mask_data),
        .I_clr_pending(clr),
        .I_int_ack    (ack),
        .O_int        (o_int),
        .O_int_vector (o_vec),
        .O_pending    (o_pend),
        .O_mask       (o_mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_int", 32'(o_int), 32'd0);
        check("rst_vec", 32'(o_vec), 32'd0);
        check("rst_pend", 32'(o_pend), 32'h0);
        check("rst_mask", 32'(o_mask), 32'hF);
        rst_n = 1'b1;
        tick();

        // Single edge on irq2
        irq = 4'b0100;
        tick();
        irq = 4'b0000;
        tick();
        check("t1_pend_early", 32'(o_pend), 32'h0);
        tick();
        check("t1_pend_c3", 32'(o_pend), 32'h4);
        check("t1_int_c3", 32'(o_int), 32'd0);
        tick();
        check("t1_int_c4", 32'(o_int), 32'd1);
        check("t1_vec_c4", 32'(o_vec), 32'd2);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t1_hold_int", 32'(o_int), 32'd1);
        end
        check("t1_hold_vec", 32'(o_vec), 32'd2);
        clr = 4'b0100;
        tick();
        clr = 4'b0000;
        check("t1_clr_pend", 32'(o_pend), 32'h0);
        check("t1_clr_int_held", 32'(o_int), 32'd1);
        check("t1_clr_vec_held", 32'(o_vec), 32'd2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t1_ack_int", 32'(o_int), 32'd0);
        tick();
        tick();
        check("t1_idle_int", 32'(o_int), 32'd0);

        // Priority and ack: irq3 and irq1 together
        irq = 4'b1010;
        tick();
        irq = 4'b0000;
        tick();
        tick();
        check("t2_pend", 32'(o_pend), 32'hA);
        tick();
        check("t2_int1", 32'(o_int), 32'd1);
        check("t2_vec1", 32'(o_vec), 32'd1);
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t2_ack1_int", 32'(o_int), 32'd0);
        check("t2_ack1_pend", 32'(o_pend), 32'h8);
        tick();
        check("t2_gap_int", 32'(o_int), 32'd0);
        tick();
        check("t2_int3", 32'(o_int), 32'd1);
        check("t2_vec3", 32'(o_vec), 32'd3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t2_ack3_int", 32'(o_int), 32'd0);
        check("t2_ack3_pend", 32'(o_pend), 32'h0);
        tick();
        tick();

        // Stalled ack on irq0
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        tick();
        tick();
        tick();
        check("t3_int", 32'(o_int), 32'd1);
        check("t3_vec", 32'(o_vec), 32'd0);
        ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_stall_int", 32'(o_int), 32'd0);
            check("t3_stall_pend", 32'(o_pend), 32'h0);
        end
        ack = 1'b0;
        tick();
        check("t3_fall_int", 32'(o_int), 32'd0);
        tick();
        check("t3_no_rereq", 32'(o_int), 32'd0);

        // Spurious ack in IDLE
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("spur_int", 32'(o_int), 32'd0);
        check("spur_pend", 32'(o_pend), 32'h0);
        tick();

        // Mask
        mask_we = 1'b1;
        mask_data = 4'b1110;
        tick();
        mask_we = 1'b0;
        check("t4_mask", 32'(o_mask), 32'hE);
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        tick();
        tick();
        check("t4_pend", 32'(o_pend), 32'h1);
        tick();
        tick();
        check("t4_masked_int", 32'(o_int), 32'd0);
        mask_we = 1'b1;
        mask_data = 4'b1111;
        tick();
        mask_we = 1'b0;
        check("t4_unmask_c1", 32'(o_int), 32'd0);
        tick();
        check("t4_unmask_int", 32'(o_int), 32'd1);
        check("t4_unmask_vec", 32'(o_vec), 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        tick();

        // Race: new irq1 edge lands on the ack that retires irq1
        irq = 4'b0010;
        tick();
        irq = 4'b0000;
        tick();
        tick();
        tick();
        check("t5_int", 32'(o_int), 32'd1);
        check("t5_vec", 32'(o_vec), 32'd1);
        irq = 4'b0010;
        tick();
        irq = 4'b0000;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t5_race_pend", 32'(o_pend), 32'h2);
        check("t5_race_int", 32'(o_int), 32'd0);
        tick();
        tick();
        check("t5_second_int", 32'(o_int), 32'd1);
        check("t5_second_vec", 32'(o_vec), 32'd1);
        mask_we = 1'b1;
        mask_data = 4'b0110;
        tick();
        mask_we = 1'b0;
        check("t5_mask_in_req", 32'(o_mask), 32'h6);
        check("t5_req_held", 32'(o_int), 32'd1);

        // Asynchronous reset mid-REQ
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_int", 32'(o_int), 32'd0);
        check("t6_rst_pend", 32'(o_pend), 32'h0);
        check("t6_rst_mask", 32'(o_mask), 32'hF);
        check("t6_rst_vec", 32'(o_vec), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t6_post_int", 32'(o_int), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
